coin_pulse_gen: RTL
===================

# coin_pulse_gen

Coin-input front end for the cola vending state machine. Two raw, bouncy, asynchronous coin-sensor lines (1-cent and 2-cent slots) are synchronised and debounced. Each accepted coin adds credit to a pending counter. The counter drains as a train of single-cycle 1-cent pulses on `CENT1OUT`. That output drives the vending FSM's 1-cent coin input, and the FSM's dispense output feeds back on `TIN_BUSY`.

## Interface
- `DEBOUNCE_CYC`, default 4: consecutive stable cycles after synchronisation before a level change is accepted (production builds override, e.g. 500000); legal range ≥ 1.
- `GAP_CYC`, default 2: minimum idle cycles inserted after every output pulse; legal range ≥ 1.
- `DB_W`, default 20: width of the debounce counter; must satisfy 2^DB_W > DEBOUNCE_CYC.
- `CLK` input 1: single clock; all state on its rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `COIN1_RAW` input 1: raw 1-cent sensor level; asynchronous; high = coin present.
- `COIN2_RAW` input 1: raw 2-cent sensor level; asynchronous.
- `TIN_BUSY` input 1: high while the downstream FSM is dispensing; it ignores coin input in that state.
- `CENT1OUT` output 1: registered one-cycle pulse, one per cent of credit.
- `PENDING` output 3: current undrained credit, 0..7.
- `CREDIT_OVF` output 1: sticky flag, set when credit was lost to saturation.

## Operation
- Synchroniser: each raw line passes through two flops before any use; reset value 0.
- Debouncer (per line): holds a debounced level `db` (reset 0) and a counter (reset 0).
  - If sync output equals `db`, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYC-1` and sync still differs, `db` takes the sync value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYC` cycles produces no change.
- Coin acceptance happens on the `db` 0→1 transition only; falling transitions add nothing.
  - 1-cent line adds 1.
  - 2-cent line adds 2.
  - Both in the same edge add 3.
- Credit counter: 3 bits, reset 0. At each edge the new value is old + adds − (1 if a pulse launches this edge).
  - If the result exceeds 7, it saturates at 7 and sets `CREDIT_OVF`.
  - `CREDIT_OVF` clears only on reset.
- Emitter FSM (reset to IDLE):
  - IDLE → PULSE when `PENDING` > 0 and `TIN_BUSY`==0 at the edge; credit decrements by 1 at that same edge.
  - PULSE → GAP unconditionally, loading the gap counter with `GAP_CYC`.
  - GAP: the counter decrements each cycle; GAP → IDLE when it reaches 1.
  - IDLE with `PENDING`==0 or `TIN_BUSY`==1: stay in IDLE.
- `CENT1OUT` = 1 exactly while in PULSE. It is registered state, with no combinational path from any input.
- Add and launch in the same edge are both applied; the net change can be 0.

## Timing
- Reset values: `CENT1OUT`=0, `PENDING`=0, `CREDIT_OVF`=0, FSM=IDLE, all sync/db/counter flops 0. Reset may assert in any state and drops pending credit.
- Raw rise held stable from before edge 1: credit increments at edge 2+`DEBOUNCE_CYC`.
  - `CENT1OUT` is high in the cycle after edge 3+`DEBOUNCE_CYC`, provided the emitter is idle and `TIN_BUSY` is low.
- Pulse spacing is at least `GAP_CYC`+2 cycles rising-to-rising. With defaults, consecutive pulses come every 4 cycles.
- Spacing ≥ 3 guarantees the downstream FSM has left its dispense state before the next pulse. `TIN_BUSY` additionally blocks launch.
- `TIN_BUSY` is sampled only in IDLE. A high level delays launch cycle-by-cycle and loses no credit.

## Test plan
- Clean 1-cent coin: reset, release `RST_N`, hold `COIN1_RAW`=1 from cycle 5 for 20 cycles.
  - Required: exactly one `CENT1OUT` pulse, 3+`DEBOUNCE_CYC` cycles after the first sampling edge.
  - Required: `PENDING` goes 0→1→0.
  - Required: `CREDIT_OVF`=0.
- Bounce: toggle `COIN1_RAW` 1,0,1,0 with 1–3-cycle widths, then hold 1 for 10 cycles.
  - Required: exactly one pulse.
  - Required: 3-cycle glitches alone (`DEBOUNCE_CYC`=4) produce no pulse.
- 2-cent plus simultaneous coins: one 2-cent coin, then 1-cent and 2-cent accepted in the same edge.
  - Required: `PENDING` reaches 2, then 3 (accounting for drain).
  - Required: 5 pulses total, spaced exactly 4 cycles apart.
- `TIN_BUSY` hold-off: pending=2, `TIN_BUSY` forced high for 10 cycles.
  - Required: no `CENT1OUT` while high.
  - Required: the first pulse appears in the cycle after the first edge sampling `TIN_BUSY`=0.
  - Required: `PENDING` stays 2 during the hold.
- Saturation: with `TIN_BUSY`=1, accept four 2-cent coins.
  - Required: `PENDING`=7 and `CREDIT_OVF`=1.
  - Then release: exactly 7 pulses, after which `CREDIT_OVF` is still 1.
- End-to-end with the vending FSM: connect `CENT1OUT` → `CENT1IN` and `TINOUT` → `TIN_BUSY`, then insert coins of 2+1+2+1.
  - Required: exactly two `TINOUT` cycles and no lost cents.
  - Also assert `RST_N` low mid-train: all outputs read 0 immediately (asynchronously).

Source files
------------

// File: rtl/coin_pulse_gen.sv
// coin_pulse_gen: synchronises and debounces two coin sensors, accumulates credit
// and drains it as spaced single-cycle 1-cent pulses for the vending FSM.
module coin_pulse_gen #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int GAP_CYC      = 2,
    parameter int DB_W         = 20
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       COIN1_RAW,
    input  logic       COIN2_RAW,
    input  logic       TIN_BUSY,
    output logic       CENT1OUT,
    output logic [2:0] PENDING,
    output logic       CREDIT_OVF
);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    logic [1:0] meta, sync, rise;
    state_t state, state_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic launch;
    logic [3:0] sum;

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= {COIN2_RAW, COIN1_RAW};
            sync <= meta;
        end

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic db;
        logic [DB_W-1:0] cnt;
        // credit lands on the same edge the debounced level rises
        assign rise[i] = sync[i] & ~db & (cnt == DB_LAST);
        always_ff @(posedge CLK or negedge RST_N)
            if (!RST_N) begin
                db  <= 1'b0;
                cnt <= '0;
            end else if (sync[i] == db) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                db  <= sync[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
    end

    always_comb begin
        launch  = (state == IDLE) && (PENDING != 3'd0) && !TIN_BUSY;
        sum     = {1'b0, PENDING} + {3'b0, rise[0]} + {2'b0, rise[1], 1'b0} - {3'b0, launch};
        state_n = launch ? PULSE :
                  (state == PULSE) ? GAP :
                  (state == GAP && gap_cnt == GW'(1)) ? IDLE : state;
        gap_n   = (state == PULSE) ? GAP_LOAD :
                  (state == GAP) ? gap_cnt - 1'b1 : gap_cnt;
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            PENDING    <= '0;
            CREDIT_OVF <= 1'b0;
            CENT1OUT   <= 1'b0;
        end else begin
            state      <= state_n;
            gap_cnt    <= gap_n;
            PENDING    <= (sum > 4'd7) ? 3'd7 : sum[2:0];
            CREDIT_OVF <= CREDIT_OVF | (sum > 4'd7);
            CENT1OUT   <= (state_n == PULSE);
        end
endmodule
